// File: rtl/matriz_varredura_pkg.sv
// rtl/matriz_varredura_pkg.sv - shared types, mode codes and glyph table for the LED row scanner
package matriz_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } estado_t;

  localparam logic [1:0] MODO_OFF      = 2'd0;
  localparam logic [1:0] MODO_GOTEJO   = 2'd1;
  localparam logic [1:0] MODO_ASPERSOR = 2'd2;
  localparam logic [1:0] MODO_ALARME   = 2'd3;

  localparam int GLYPH_ROWS = 7;
  localparam int GLYPH_COLS = 5;

  // Indexed [mode][frame][row]; row 0 is the top row of the matrix.
  localparam logic [4:0] GLYPH [4][2][7] = '{
    '{ '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000},
       '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000} },
    '{ '{5'b00100, 5'b00100, 5'b01110, 5'b01110, 5'b11111, 5'b11111, 5'b01110},
       '{5'b00000, 5'b00100, 5'b00100, 5'b01110, 5'b11111, 5'b11111, 5'b01110} },
    '{ '{5'b10101, 5'b01010, 5'b10101, 5'b00100, 5'b00100, 5'b00100, 5'b01110},
       '{5'b01010, 5'b10101, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b01110} },
    '{ '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11111},
       '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000} }
  };

  function automatic logic [2:0] proxima_linha(input logic [2:0] r, input int rows);
    return (int'(r) == rows - 1) ? 3'd0 : r + 3'd1;
  endfunction

endpackage

// File: rtl/matriz_varredura_if.sv
// rtl/matriz_varredura_if.sv - strobe/mode inputs and matrix drive outputs of the row scanner
interface matriz_varredura_if #(
  parameter int ROWS = 7,
  parameter int COLS = 5
);
  logic            scan_tick;
  logic            frame_tick;
  logic [1:0]      modo;
  logic [ROWS-1:0] linhas;
  logic [COLS-1:0] colunas;
  logic [2:0]      linha_idx;
  logic            quadro;

  modport master (
    output scan_tick, frame_tick, modo,
    input  linhas, colunas, linha_idx, quadro
  );

  modport slave (
    input  scan_tick, frame_tick, modo,
    output linhas, colunas, linha_idx, quadro
  );
endinterface

// File: rtl/matriz_varredura_glyph_rom.sv
// rtl/matriz_varredura_glyph_rom.sv - combinational glyph lookup (mode, frame, row) -> columns
module matriz_glyph_rom
  import matriz_pkg::*;
(
  input  logic [1:0]            i_modo,
  input  logic                  i_quadro,
  input  logic [2:0]            i_row,
  output logic [GLYPH_COLS-1:0] o_colunas
);

  always_comb begin
    o_colunas = '0;
    if (i_row < 3'd7) o_colunas = GLYPH[i_modo][i_quadro][i_row];
  end

endmodule

// File: rtl/matriz_varredura.sv
// rtl/matriz_varredura.sv - 7x5 LED row-scan driver; MATRIX_BLANK_EN adds all-off time between rows
module matriz_varredura
  import matriz_pkg::*;
#(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int BLANK_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  matriz_varredura_if.slave bus
);

  localparam int             CW        = $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0]  BLANK_INI = CW'(BLANK_CYCLES - 1);
`ifdef MATRIX_BLANK_EN
  localparam bit             BLANK_EN  = 1'b1;
`else
  localparam bit             BLANK_EN  = 1'b0;
`endif
  localparam estado_t        ESTADO_INI = BLANK_EN ? BLANK : DRIVE;

  estado_t         r_estado;
  logic [CW-1:0]   r_blank_cnt;
  logic [2:0]      r_row;
  logic            r_quadro;
  logic            r_pend;
  logic [1:0]      r_modo;
  logic [ROWS-1:0] r_linhas;
  logic [COLS-1:0] r_colunas;

  estado_t               w_estado_n;
  logic [CW-1:0]         w_cnt_n;
  logic [2:0]            w_row_n;
  logic                  w_quadro_n;
  logic                  w_pend_n;
  logic [1:0]            w_modo_n;
  logic                  w_fronteira;
  logic [ROWS-1:0]       w_linhas_n;
  logic [COLS-1:0]       w_colunas_n;
  logic [GLYPH_COLS-1:0] w_glyph;

  matriz_glyph_rom u_rom (
    .i_modo    (w_modo_n),
    .i_quadro  (w_quadro_n),
    .i_row     (w_row_n),
    .o_colunas (w_glyph)
  );

  always_comb begin
    w_estado_n  = r_estado;
    w_cnt_n     = r_blank_cnt;
    w_row_n     = r_row;
    w_fronteira = 1'b0;
    case (r_estado)
      BLANK: begin
        if (r_blank_cnt == '0) begin
          w_estado_n  = DRIVE;
          w_fronteira = (r_row == 3'd0);
        end else begin
          w_cnt_n = r_blank_cnt - 1'b1;
        end
      end
      DRIVE: begin
        if (bus.scan_tick) begin
          w_row_n = proxima_linha(r_row, ROWS);
          if (BLANK_EN) begin
            w_estado_n = BLANK;
            w_cnt_n    = BLANK_INI;
          end else begin
            w_fronteira = (w_row_n == 3'd0);
          end
        end
      end
      default: w_estado_n = ESTADO_INI;
    endcase

    // Mode and frame only change at the row-0 boundary so a frame is never torn.
    w_modo_n   = r_modo;
    w_quadro_n = r_quadro;
    w_pend_n   = r_pend | bus.frame_tick;
    if (w_fronteira) begin
      w_modo_n   = bus.modo;
      w_quadro_n = r_quadro ^ w_pend_n;
      w_pend_n   = 1'b0;
    end

    w_linhas_n  = '1;
    w_colunas_n = '0;
    if (w_estado_n == DRIVE) begin
      w_linhas_n  = ~(ROWS'(1) << w_row_n);
      w_colunas_n = COLS'(w_glyph);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado    <= ESTADO_INI;
      r_blank_cnt <= BLANK_INI;
      r_row       <= 3'd0;
      r_quadro    <= 1'b0;
      r_pend      <= 1'b0;
      r_modo      <= MODO_OFF;
      r_linhas    <= '1;
      r_colunas   <= '0;
    end else begin
      r_estado    <= w_estado_n;
      r_blank_cnt <= w_cnt_n;
      r_row       <= w_row_n;
      r_quadro    <= w_quadro_n;
      r_pend      <= w_pend_n;
      r_modo      <= w_modo_n;
      r_linhas    <= w_linhas_n;
      r_colunas   <= w_colunas_n;
    end
  end

  assign bus.linhas    = r_linhas;
  assign bus.colunas   = r_colunas;
  assign bus.linha_idx = r_row;
  assign bus.quadro    = r_quadro;

endmodule

// File: tb/tb_matriz_varredura.sv
// tb/tb_matriz_varredura.sv - directed self-checking bench for matriz_varredura (either MATRIX_BLANK_EN build)
module tb_matriz_varredura;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  matriz_varredura_if #(.ROWS(7), .COLS(5)) bus ();

  matriz_varredura #(.ROWS(7), .COLS(5), .BLANK_CYCLES(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam logic [6:0] LIN [7] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F};
  localparam logic [4:0] GOTA0 [7] = '{5'b00100, 5'b00100, 5'b01110, 5'b01110, 5'b11111, 5'b11111, 5'b01110};
`ifdef MATRIX_BLANK_EN
  localparam logic [4:0] COL_INI  = 5'b11111;
  localparam logic [4:0] POS_RST0 = 5'b10101;
  localparam logic [4:0] POS_RST1 = 5'b01010;
`else
  localparam logic [4:0] COL_INI  = 5'b00000;
  localparam logic [4:0] POS_RST0 = 5'b00000;
  localparam logic [4:0] POS_RST1 = 5'b00000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_row(input int idx, input logic [4:0] col, input logic q);
    chk($sformatf("linha_idx r%0d", idx), 32'(bus.linha_idx), 32'(idx));
    chk($sformatf("linhas r%0d", idx), 32'(bus.linhas), 32'(LIN[idx]));
    chk($sformatf("colunas r%0d", idx), 32'(bus.colunas), 32'(col));
    chk($sformatf("quadro r%0d", idx), 32'(bus.quadro), 32'(q));
  endtask

  // Counts all-off cycles until a row lights; optionally fires a stray scan_tick mid-blank.
  task automatic count_blank(input bit inj);
    int n;
    n = 0;
    while (bus.linhas === 7'h7F && n < 200) begin
      n++;
      bus.scan_tick = inj && (n == 10);
      @(negedge clock);
    end
    bus.scan_tick = 1'b0;
    chk("blank_len", 32'(n), 32'd64);
  endtask

  task automatic advance(input logic ft, input bit inj);
    bus.scan_tick  = 1'b1;
    bus.frame_tick = ft;
    @(negedge clock);
    bus.scan_tick  = 1'b0;
    bus.frame_tick = 1'b0;
`ifdef MATRIX_BLANK_EN
    count_blank(inj);
`else
    if (inj) @(negedge clock);
`endif
  endtask

  task automatic wait_row0();
`ifdef MATRIX_BLANK_EN
    count_blank(1'b0);
`else
    @(negedge clock);
`endif
  endtask

  initial begin
    bus.scan_tick  = 1'b0;
    bus.frame_tick = 1'b0;
    bus.modo       = 2'd3;
    reset          = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst linhas", 32'(bus.linhas), 32'h7F);
    chk("rst colunas", 32'(bus.colunas), 32'h0);
    chk("rst idx", 32'(bus.linha_idx), 32'h0);
    chk("rst quadro", 32'(bus.quadro), 32'h0);

    reset = 1'b1;
    wait_row0();
    check_row(0, COL_INI, 1'b0);
    repeat (5) @(negedge clock);
    check_row(0, COL_INI, 1'b0);

    for (int i = 1; i < 7; i++) begin
      advance(1'b0, 1'b0);
      check_row(i, COL_INI, 1'b0);
    end
    advance(1'b0, 1'b0);
    check_row(0, 5'b11111, 1'b0);

    advance(1'b0, 1'b0);
    advance(1'b0, 1'b1);
    check_row(2, 5'b11111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.frame_tick = 1'b1;
      @(negedge clock);
      bus.frame_tick = 1'b0;
      repeat (2) @(negedge clock);
      chk("quadro held", 32'(bus.quadro), 32'h0);
    end
    for (int i = 3; i < 7; i++) begin
      advance(1'b0, 1'b0);
      check_row(i, 5'b11111, 1'b0);
    end
    advance(1'b0, 1'b0);
    check_row(0, 5'b00000, 1'b1);

    bus.modo = 2'd1;
    repeat (3) @(negedge clock);
    check_row(0, 5'b00000, 1'b1);
    for (int i = 1; i < 7; i++) begin
      advance(1'b0, 1'b0);
      check_row(i, 5'b00000, 1'b1);
    end
    advance(1'b1, 1'b0);
    check_row(0, GOTA0[0], 1'b0);
    for (int i = 1; i < 5; i++) begin
      advance(1'b0, 1'b0);
      check_row(i, GOTA0[i], 1'b0);
    end
    bus.modo = 2'd2;
    for (int i = 5; i < 7; i++) begin
      advance(1'b0, 1'b0);
      check_row(i, GOTA0[i], 1'b0);
    end
    advance(1'b0, 1'b0);
    check_row(0, 5'b10101, 1'b0);
    advance(1'b0, 1'b0);
    check_row(1, 5'b01010, 1'b0);
    advance(1'b0, 1'b0);
    advance(1'b0, 1'b0);
    check_row(3, 5'b00100, 1'b0);

    #2 reset = 1'b0;
    #1;
    chk("async linhas", 32'(bus.linhas), 32'h7F);
    chk("async colunas", 32'(bus.colunas), 32'h0);
    chk("async idx", 32'(bus.linha_idx), 32'h0);
    chk("async quadro", 32'(bus.quadro), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    wait_row0();
    check_row(0, POS_RST0, 1'b0);
    advance(1'b0, 1'b0);
    check_row(1, POS_RST1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
